// File: rtl/irq_controller.sv
// Eight-source prioritised interrupt controller: PRIO/ENABLE/FLAGS registers,
// fixed-priority arbitration and an IDLE/REQ/CLEAR request handshake to the CPU.
module irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  irq_sources,
  input  logic [1:0]  cpu_level,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [2:0]  irq_index,
  output logic [1:0]  irq_level
);

  localparam logic [23:0] A_PRIO   = 24'h002020;
  localparam logic [23:0] A_ENABLE = 24'h002023;
  localparam logic [23:0] A_FLAGS  = 24'h002027;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLEAR} state_t;

  state_t      r_state;
  logic [7:0]  r_prio;
  logic [7:0]  r_enable;
  logic [7:0]  r_flags;
  logic        r_irq_req;
  logic [2:0]  r_irq_index;
  logic [1:0]  r_irq_level;

  logic [7:0]  w_pending;
  logic        w_win_vld;
  logic [2:0]  w_win_idx;
  logic [1:0]  w_win_lvl;
  logic        w_eligible;
  logic        w_wr_prio;
  logic        w_wr_enable;
  logic        w_wr_flags;
  logic        w_ack;
  logic [7:0]  w_clr;
  logic [7:0]  w_flags_nxt;

  // Sources 2g and 2g+1 share the two-bit priority field of group g.
  function automatic logic [1:0] grp_prio(input logic [7:0] prio, input logic [2:0] src);
    logic [1:0] lvl;
    case (src[2:1])
      2'd0:    lvl = prio[1:0];
      2'd1:    lvl = prio[3:2];
      2'd2:    lvl = prio[5:4];
      default: lvl = prio[7:6];
    endcase
    return lvl;
  endfunction

  always_comb begin
    w_pending = 8'h00;
    for (int i = 0; i < 8; i++)
      w_pending[i] = r_flags[i] & r_enable[i] & (grp_prio(r_prio, 3'(i)) != 2'd0);
  end

  // Scan from the top index down with >= so equal priorities resolve to the lowest index.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = 3'd0;
    w_win_lvl = 2'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_pending[i] && (grp_prio(r_prio, 3'(i)) >= w_win_lvl)) begin
        w_win_vld = 1'b1;
        w_win_idx = 3'(i);
        w_win_lvl = grp_prio(r_prio, 3'(i));
      end
    end
  end

  assign w_eligible  = w_win_vld && ((w_win_lvl > cpu_level) || (w_win_lvl == 2'd3));
  assign w_wr_prio   = bus_write && (bus_address_in == A_PRIO);
  assign w_wr_enable = bus_write && (bus_address_in == A_ENABLE);
  assign w_wr_flags  = bus_write && (bus_address_in == A_FLAGS);
  assign w_ack       = (r_state == S_REQ) && irq_ack;

  // New source pulses win over any clear landing in the same cycle.
  assign w_clr       = (w_wr_flags ? bus_data_in : 8'h00) |
                       (w_ack ? (8'd1 << r_irq_index) : 8'h00);
  assign w_flags_nxt = (r_flags & ~w_clr) | irq_sources;

  always_ff @(posedge clk) begin
    if (clk_ce) begin
      if (!reset) begin
        r_prio      <= 8'h00;
        r_enable    <= 8'h00;
        r_flags     <= 8'h00;
        r_state     <= S_IDLE;
        r_irq_req   <= 1'b0;
        r_irq_index <= 3'd0;
        r_irq_level <= 2'd0;
      end else begin
        if (w_wr_prio)   r_prio   <= bus_data_in;
        if (w_wr_enable) r_enable <= bus_data_in;
        r_flags <= w_flags_nxt;
        case (r_state)
          S_IDLE: begin
            if (w_eligible) begin
              r_irq_index <= w_win_idx;
              r_irq_level <= w_win_lvl;
              r_irq_req   <= 1'b1;
              r_state     <= S_REQ;
            end
          end
          S_REQ: begin
            if (irq_ack) begin
              r_irq_req <= 1'b0;
              r_state   <= S_CLEAR;
            end else if (!w_pending[r_irq_index]) begin
              r_irq_req <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: begin
            r_irq_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (bus_read) begin
      case (bus_address_in)
        A_PRIO:   bus_data_out = r_prio;
        A_ENABLE: bus_data_out = r_enable;
        A_FLAGS:  bus_data_out = r_flags;
        default:  bus_data_out = 8'h00;
      endcase
    end
  end

  assign irq_req   = r_irq_req;
  assign irq_index = r_irq_index;
  assign irq_level = r_irq_level;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes on posedge clk, only when clk_ce=1.
REQ-003 reset  input  1  synchronous active-low reset, sampled on posedge clk when clk_ce=1.
REQ-004 clk_ce  input  1  clock enable.
REQ-005 bus_write  input  1  register write strobe.
REQ-006 bus_read  input  1  register read strobe; has no side effects.
REQ-007 bus_address_in  input  24  register address.
REQ-008 bus_data_in  input  8  write data.
REQ-009 bus_data_out  output  8  combinational read data.
REQ-010 irq_sources  input  8  one-cycle request pulses; bits [2:0] come from timer irqs[2:0], bits [7:3] are reserved for other peripherals.
REQ-011 cpu_level  input  2  current CPU interrupt mask level.
REQ-012 irq_ack  input  1  single-cycle CPU acknowledge.
REQ-013 irq_req  output  1  registered interrupt request to the CPU.
REQ-014 irq_index  output  3  registered index of the presented source.
REQ-015 irq_level  output  2  registered priority of the presented source.

Function
REQ-016 Registers:
- 0x2020 PRIO[7:0]: group g (sources 2g and 2g+1) uses PRIO[2g+1:2g].
- 0x2023 ENABLE[7:0].
- 0x2027 FLAGS[7:0].
REQ-017 Reads of 0x2020, 0x2023 and 0x2027 SHALL return the register value; all other addresses SHALL read 8'h00.
REQ-018 PRIO and ENABLE writes SHALL take effect in the clk_ce cycle in which bus_write=1.
REQ-019 A FLAGS write SHALL be write-1-to-clear; data bits written as 0 leave their flag unchanged.
REQ-020 In a clk_ce cycle with irq_sources[i]=1, FLAGS[i] SHALL set, whatever the ENABLE and PRIO values.
REQ-021 A simultaneous set and clear of the same flag (write-1-to-clear or ack clear) SHALL leave the flag set.
REQ-022 pending[i] = FLAGS[i] & ENABLE[i] & (group priority != 0).
REQ-023 The arbitration winner SHALL be the pending source with the highest group priority; ties go to the lowest index.
REQ-024 The winner is eligible only if its priority > cpu_level, or its priority == 3, which is unmaskable.
REQ-025 The state machine SHALL have three states: IDLE, REQ and CLEAR.
REQ-026 IDLE: if an eligible winner exists, latch irq_index and irq_level, set irq_req=1 and go to REQ in the same clk_ce cycle; this gives 1 clk_ce cycle from flag set to irq_req.
REQ-027 REQ: irq_index and irq_level SHALL stay frozen, with no preemption by higher-priority arrivals.
REQ-028 REQ, irq_ack=1: clear FLAGS[irq_index], drop irq_req and go to CLEAR.
REQ-029 REQ, no ack, latched source no longer pending (flag cleared by bus, enable cleared, or priority set to 0): withdraw irq_req and go to IDLE.
REQ-030 REQ with a cpu_level change: no effect; eligibility is checked only in IDLE.
REQ-031 CLEAR: irq_req=0 for one clk_ce cycle, then go to IDLE and re-arbitrate.
REQ-032 irq_ack outside REQ SHALL be ignored.
REQ-033 With clk_ce=0, all state and outputs SHALL hold.

Reset
REQ-034 With reset=0 at a clk_ce edge, PRIO, ENABLE and FLAGS SHALL be 8'h00; irq_req=0, irq_index=0, irq_level=0; state IDLE.
REQ-035 Reset SHALL take precedence over simultaneous source pulses, writes and ack.
REQ-036 Reset asserted in REQ SHALL drop irq_req in the same cycle; no flag survives the reset.

Verification
REQ-037 PRIO=8'h02, ENABLE=8'h01, cpu_level=0, pulse irq_sources[0] -> irq_req=1, index=0, level=2 one clk_ce later; ack -> FLAGS=0, irq_req=0 for at least 2 cycles.
REQ-038 PRIO=8'h31 (group0=1, group2=3), ENABLE=8'hFF, pulse sources 1 and 4 together -> index=4, level=3; after ack -> index=1, level=1.
REQ-039 cpu_level=3, PRIO group0=2, source 0 pending -> irq_req stays 0; set cpu_level=1 -> irq_req=1 next cycle.
REQ-040 In REQ with index=2, write 0x2027 with 8'h04 -> irq_req withdrawn next cycle, FLAGS[2]=0, no ack needed.
REQ-041 Write-1-to-clear of FLAGS[0] in the same cycle as an irq_sources[0] pulse -> FLAGS[0]=1; read of 0x2027 returns 8'h01.
REQ-042 reset=0 while irq_req=1 -> all registers 0 and irq_req=0 on that edge; releasing reset with no pulses -> irq_req stays 0.
